// File: rtl/pulse_interval_monitor_if.sv
// Control and status bundle between the tick-interval monitor and its controller.
// The controller side drives the inputs; the monitor side returns the measured results.
interface pulse_interval_monitor_if #(
    parameter int CNT_W = 30
);
    logic             enable;
    logic             pulse_in;
    logic             clear;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             timeout;
    logic             busy;

    modport master (
        output enable, pulse_in, clear,
        input  period, period_valid, timeout, busy
    );

    modport slave (
        input  enable, pulse_in, clear,
        output period, period_valid, timeout, busy
    );
endinterface

// File: rtl/pulse_interval_monitor.sv
// Measures the clk-cycle interval between rising edges of a tick stream.
// A sticky timeout is raised when no tick arrives within TIMEOUT_CYCLES cycles.
module pulse_interval_monitor #(
    parameter int TIMEOUT_CYCLES = 600_000_000,
    parameter int CNT_W          = 30
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pulse_interval_monitor_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE,
        TIMED_OUT
    } state_t;

    localparam logic [CNT_W:0] C_THRESHOLD = (CNT_W+1)'(TIMEOUT_CYCLES);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_period;
    logic             r_pulse_d;
    logic             r_period_valid;
    logic             r_timeout;
    logic             r_busy;

    logic             w_event;
    logic [CNT_W:0]   w_count_inc;
    logic             w_at_threshold;

    // One extra bit so count+1 cannot wrap before it is compared.
    assign w_event        = bus.pulse_in & ~r_pulse_d;
    assign w_count_inc    = {1'b0, r_count} + (CNT_W+1)'(1);
    assign w_at_threshold = (w_count_inc == C_THRESHOLD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_count        <= '0;
            r_period       <= '0;
            r_pulse_d      <= 1'b0;
            r_period_valid <= 1'b0;
            r_timeout      <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_pulse_d      <= bus.pulse_in;
            r_period_valid <= 1'b0;
            // Any enabled state leads to a non-IDLE state next cycle.
            r_busy         <= bus.enable;

            // A timeout raised below overrides this clear.
            if (bus.clear) begin
                r_timeout <= 1'b0;
            end

            if (!bus.enable) begin
                r_state <= IDLE;
                r_count <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_state <= WAIT_FIRST;
                        r_count <= '0;
                    end
                    WAIT_FIRST, MEASURE: begin
                        if (w_event) begin
                            r_state <= MEASURE;
                            r_count <= '0;
                            // Only a second tick gives a complete interval.
                            if (r_state == MEASURE) begin
                                r_period       <= w_count_inc[CNT_W-1:0];
                                r_period_valid <= 1'b1;
                            end
                        end else if (w_at_threshold) begin
                            r_state   <= TIMED_OUT;
                            r_timeout <= 1'b1;
                        end else begin
                            r_count <= w_count_inc[CNT_W-1:0];
                        end
                    end
                    TIMED_OUT: begin
                        if (w_event) begin
                            r_state <= MEASURE;
                            r_count <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.period       = r_period;
    assign bus.period_valid = r_period_valid;
    assign bus.timeout      = r_timeout;
    assign bus.busy         = r_busy;
endmodule

// File: tb/tb_pulse_interval_monitor.sv
// Directed bench for pulse_interval_monitor with a 20-cycle timeout and 5-bit counter.
// Cycle c means the inputs applied before the c-th clock edge of a phase.
module tb_pulse_interval_monitor;
    localparam int TIMEOUT_CYCLES = 20;
    localparam int CNT_W          = 5;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    pulse_interval_monitor_if #(.CNT_W(CNT_W)) bus ();

    pulse_interval_monitor #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic chk_outs(input string tag, input logic pv, input int per,
                            input logic to, input logic bsy);
        chk_eq({tag, "_pv"},      32'(bus.period_valid), 32'(pv));
        chk_eq({tag, "_period"},  32'(bus.period),       32'(per));
        chk_eq({tag, "_timeout"}, 32'(bus.timeout),      32'(to));
        chk_eq({tag, "_busy"},    32'(bus.busy),         32'(bsy));
    endtask

    // Apply inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic en, input logic pin, input logic clr);
        bus.enable   = en;
        bus.pulse_in = pin;
        bus.clear    = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.pulse_in = 1'b0;
        bus.clear    = 1'b0;

        // Reset, then release with enable low.
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 1'b0, 0, 1'b0, 1'b0);
        #2 reset_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk_outs("idle", 1'b0, 0, 1'b0, 1'b0);

        // Ticks at 5, 15, 22: intervals 10 and 7, nothing for the first tick.
        for (int c = 0; c < 25; c++) begin
            step(1'b1, (c == 5 || c == 15 || c == 22), 1'b0);
            chk_eq("t2_pv", 32'(bus.period_valid), 32'(c == 15 || c == 22));
            chk_eq("t2_busy", 32'(bus.busy), 32'd1);
            if (c == 15) chk_eq("t2_period10", 32'(bus.period), 32'd10);
            if (c == 22) chk_eq("t2_period7", 32'(bus.period), 32'd7);
        end
        chk_eq("t2_timeout", 32'(bus.timeout), 32'd0);

        // Disable: busy drops, period holds.
        step(1'b0, 1'b0, 1'b0);
        chk_outs("dis1", 1'b0, 7, 1'b0, 1'b0);

        // Held-high tick counts once; threshold at 25 times out before tick at 30.
        for (int c = 0; c < 32; c++) begin
            step(1'b1, ((c >= 5 && c <= 9) || c == 30), 1'b0);
            chk_eq("t3_pv", 32'(bus.period_valid), 32'd0);
            chk_eq("t3_timeout", 32'(bus.timeout), 32'(c >= 25));
        end
        chk_outs("t3_end", 1'b0, 7, 1'b1, 1'b1);

        // Clear while disabled.
        step(1'b0, 1'b0, 1'b1);
        chk_outs("clr_dis", 1'b0, 7, 1'b0, 1'b0);

        // Interval of exactly 20 reports; interval of 21 times out at cycle 42.
        for (int c = 0; c < 44; c++) begin
            step(1'b1, (c == 2 || c == 22 || c == 43), 1'b0);
            chk_eq("t4_pv", 32'(bus.period_valid), 32'(c == 22));
            chk_eq("t4_timeout", 32'(bus.timeout), 32'(c >= 42));
            if (c == 22) chk_eq("t4_period20", 32'(bus.period), 32'd20);
        end

        // Fresh threshold at 63 together with clear: set wins.
        for (int c = 44; c < 64; c++) begin
            step(1'b1, 1'b0, (c == 63));
            chk_eq("t5_timeout", 32'(bus.timeout), 32'd1);
        end
        step(1'b1, 1'b0, 1'b1);
        chk_outs("t5_clear", 1'b0, 20, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_eq("t5_stays_clear", 32'(bus.timeout), 32'd0);

        // Back into MEASURE from TIMED_OUT, interval 66 -> 70.
        step(1'b1, 1'b1, 1'b0);
        chk_eq("t6_rearm_pv", 32'(bus.period_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        chk_outs("t6_p4", 1'b1, 4, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk_eq("t6_pv_single", 32'(bus.period_valid), 32'd0);
        step(1'b1, 1'b0, 1'b0);

        // Asynchronous reset between edges.
        bus.enable = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 0, 1'b0, 1'b0);
        #1 reset_n = 1'b1;

        // Measure 3 -> 8, then drop enable mid-MEASURE.
        for (int c = 0; c < 9; c++) begin
            step(1'b1, (c == 3 || c == 8), 1'b0);
        end
        chk_outs("t6_p5", 1'b1, 5, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk_outs("t6_dis", 1'b0, 5, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk_outs("t6_dis_hold", 1'b0, 5, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
